// File: rtl/mul8u_shared_sched_if.sv
// Requester/response bundle for mul8u_shared_sched; master = lanes + consumer, slave = scheduler.
// Error-check ports exist only when MUL8U_SCHED_ERRCHK_EN is defined.
interface mul8u_shared_sched_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int CNTW = 16
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*8-1:0] req_a;
  logic [NREQ*8-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [15:0]       rsp_o;
  logic [CNTW-1:0]   op_count;
  logic              busy;
`ifdef MUL8U_SCHED_ERRCHK_EN
  logic [15:0]       rsp_exact;
  logic [15:0]       rsp_err;
  logic [15:0]       err_max;
`endif

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
`ifdef MUL8U_SCHED_ERRCHK_EN
    input  rsp_exact, rsp_err, err_max,
`endif
    input  req_ready, rsp_valid, rsp_id, rsp_o, op_count, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
`ifdef MUL8U_SCHED_ERRCHK_EN
    output rsp_exact, rsp_err, err_max,
`endif
    output req_ready, rsp_valid, rsp_id, rsp_o, op_count, busy
  );
endinterface

// File: rtl/mul8u_shared_sched.sv
// Round-robin scheduler sharing one mul8u_19BL core; accept->rsp_valid in 2 edges, 1 op/cycle.
// rsp stall freezes S1/S2 (empty S1 still takes one op); MUL8U_SCHED_ERRCHK_EN adds exact/error outputs.
module mul8u_shared_sched #(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int CNTW = 16
) (
  input logic                 clk,
  input logic                 rst,
  mul8u_shared_sched_if.slave bus
);

  typedef struct packed {
    logic [7:0]     a;
    logic [7:0]     b;
    logic [IDW-1:0] id;
  } s1_t;

  typedef struct packed {
    logic [15:0]    o;
    logic [IDW-1:0] id;
`ifdef MUL8U_SCHED_ERRCHK_EN
    logic [15:0]    exact;
    logic [15:0]    err;
`endif
  } s2_t;

  // Only the top three AND terms survive; bit 7 repeats the A6&B6 term.
  function automatic logic [15:0] core_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = a & b;
    core_mul = ({p, 8'h00} & 16'hE000) | {8'h00, p[6], 7'b000_0000};
  endfunction

  s1_t             s1_q, s1_d;
  s2_t             s2_q, s2_d;
  logic            v1_q, v1_d;
  logic            v2_q, v2_d;
  logic [IDW-1:0]  rr_q, rr_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
`ifdef MUL8U_SCHED_ERRCHK_EN
  logic [15:0]     err_max_q, err_max_d;
  logic [15:0]     approx_w, exact_w;
`endif

  logic            stall, s1_en, s2_en, xfer;
  logic            any_vld, found_hi;
  logic [NREQ-1:0] hi_mask, masked, gnt_oh;
  logic [IDW-1:0]  pick_hi, pick_lo, gnt_idx, rr_nxt;
  logic [7:0]      a_sel, b_sel;

  // Requests at or above the pointer take priority; otherwise wrap to the lowest index.
  always_comb begin
    stall    = v2_q & ~bus.rsp_ready;
    s2_en    = ~stall;
    s1_en    = ~stall | ~v1_q;
    hi_mask  = '0;
    for (int i = 0; i < NREQ; i++) begin
      hi_mask[i] = (IDW'(i) >= rr_q);
    end
    masked   = bus.req_valid & hi_mask;
    found_hi = |masked;
    any_vld  = |bus.req_valid;
    pick_hi  = '0;
    pick_lo  = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (masked[i]) pick_hi = IDW'(i);
      if (bus.req_valid[i]) pick_lo = IDW'(i);
    end
    gnt_idx  = found_hi ? pick_hi : pick_lo;
    xfer     = any_vld & s1_en & ~rst;
    gnt_oh   = '0;
    a_sel    = '0;
    b_sel    = '0;
    for (int i = 0; i < NREQ; i++) begin
      gnt_oh[i] = xfer & (gnt_idx == IDW'(i));
      if (gnt_idx == IDW'(i)) begin
        a_sel = bus.req_a[i*8 +: 8];
        b_sel = bus.req_b[i*8 +: 8];
      end
    end
    rr_nxt   = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
  end

  always_comb begin
    s1_d  = s1_q;
    v1_d  = v1_q;
    s2_d  = s2_q;
    v2_d  = v2_q;
    rr_d  = rr_q;
    cnt_d = cnt_q;
`ifdef MUL8U_SCHED_ERRCHK_EN
    approx_w  = core_mul(s1_q.a, s1_q.b);
    exact_w   = {8'h00, s1_q.a} * {8'h00, s1_q.b};
    err_max_d = err_max_q;
    if (bus.rsp_valid && bus.rsp_ready && (s2_q.err > err_max_q)) begin
      err_max_d = s2_q.err;
    end
`endif
    if (s1_en) begin
      v1_d = xfer;
      if (xfer) begin
        s1_d.a  = a_sel;
        s1_d.b  = b_sel;
        s1_d.id = gnt_idx;
      end
    end
    if (s2_en) begin
      v2_d    = v1_q;
      s2_d.o  = core_mul(s1_q.a, s1_q.b);
      s2_d.id = s1_q.id;
`ifdef MUL8U_SCHED_ERRCHK_EN
      s2_d.exact = exact_w;
      s2_d.err   = (exact_w >= approx_w) ? (exact_w - approx_w) : (approx_w - exact_w);
`endif
    end
    if (xfer) begin
      rr_d  = rr_nxt;
      cnt_d = cnt_q + CNTW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q      <= '0;
      v1_q      <= 1'b0;
      s2_q      <= '0;
      v2_q      <= 1'b0;
      rr_q      <= '0;
      cnt_q     <= '0;
`ifdef MUL8U_SCHED_ERRCHK_EN
      err_max_q <= '0;
`endif
    end else begin
      s1_q      <= s1_d;
      v1_q      <= v1_d;
      s2_q      <= s2_d;
      v2_q      <= v2_d;
      rr_q      <= rr_d;
      cnt_q     <= cnt_d;
`ifdef MUL8U_SCHED_ERRCHK_EN
      err_max_q <= err_max_d;
`endif
    end
  end

  assign bus.req_ready = gnt_oh;
  assign bus.rsp_valid = v2_q;
  assign bus.rsp_id    = s2_q.id;
  assign bus.rsp_o     = s2_q.o;
  assign bus.op_count  = cnt_q;
  assign bus.busy      = v1_q | v2_q;
`ifdef MUL8U_SCHED_ERRCHK_EN
  assign bus.rsp_exact = s2_q.exact;
  assign bus.rsp_err   = s2_q.err;
  assign bus.err_max   = err_max_q;
`endif

endmodule

// File: tb/tb_mul8u_shared_sched.sv
// Scoreboard bench for mul8u_shared_sched: cycle-level occupancy model predicts grants,
// expected responses are queued at acceptance and popped by an independent monitor.
module tb_mul8u_shared_sched;
  localparam int NREQ = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  mul8u_shared_sched_if #(.NREQ(4), .IDW(2), .CNTW(16)) bif ();
  mul8u_shared_sched_if #(.NREQ(4), .IDW(2), .CNTW(4))  bif4 ();

  mul8u_shared_sched #(.NREQ(4), .IDW(2), .CNTW(16)) dut  (.clk(clk), .rst(rst), .bus(bif));
  mul8u_shared_sched #(.NREQ(4), .IDW(2), .CNTW(4))  dut4 (.clk(clk), .rst(rst), .bus(bif4));

  assign bif4.req_valid = bif.req_valid;
  assign bif4.req_a     = bif.req_a;
  assign bif4.req_b     = bif.req_b;
  assign bif4.rsp_ready = bif.rsp_ready;

  typedef struct {
    int id;
    int o;
    int ex;
    int err;
  } exp_t;

  exp_t exp_q[$];
  int   log_ids[$];
  int   m_ptr    = 0;
  int   m_cnt    = 0;
  int   m_errmax = 0;
  bit   m_v1     = 1'b0;
  bit   m_v2     = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int approx(input int a, input int b);
    int r;
    r = 0;
    if (a[7] && b[7]) r = r + 32768;
    if (a[6] && b[6]) r = r + 16384 + 128;
    if (a[5] && b[5]) r = r + 8192;
    return r;
  endfunction

  function automatic int pick(input logic [3:0] v, input int ptr);
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = (ptr + k) % NREQ;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  function automatic bit can_load();
    return !rst && (!(m_v2 && !bif.rsp_ready) || !m_v1);
  endfunction

  function automatic logic [3:0] exp_ready();
    int w;
    logic [3:0] r;
    r = 4'b0000;
    w = can_load() ? pick(bif.req_valid, m_ptr) : -1;
    if (w >= 0) r[w] = 1'b1;
    return r;
  endfunction

  // Reference model: pipeline occupancy plus RR pointer, advanced at each clock edge.
  initial begin : model
    forever begin
      @(posedge clk);
      if (rst) begin
        m_ptr = 0; m_cnt = 0; m_v1 = 0; m_v2 = 0; m_errmax = 0;
        exp_q.delete();
      end else begin
        bit   stl;
        bit   can;
        int   w;
        exp_t e;
        stl = m_v2 && !bif.rsp_ready;
        can = !stl || !m_v1;
        w   = can ? pick(bif.req_valid, m_ptr) : -1;
        if (!stl) m_v2 = m_v1;
        if (can) m_v1 = (w >= 0);
        if (w >= 0) begin
          int a, b;
          a     = int'(bif.req_a[w*8 +: 8]);
          b     = int'(bif.req_b[w*8 +: 8]);
          e.id  = w;
          e.o   = approx(a, b);
          e.ex  = a * b;
          e.err = (e.ex >= e.o) ? e.ex - e.o : e.o - e.ex;
          exp_q.push_back(e);
          m_ptr = (w + 1) % NREQ;
          m_cnt = m_cnt + 1;
        end
      end
    end
  end

  initial begin : monitor
    bit          prev_stall = 1'b0;
    logic [15:0] prev_o     = '0;
    logic [1:0]  prev_id    = '0;
    exp_t        e;
    forever begin
      @(negedge clk);
      chk("req_ready", bif.req_ready, exp_ready());
      chk("rsp_valid", bif.rsp_valid, m_v2);
      chk("busy", bif.busy, m_v1 | m_v2);
      chk("op_count", bif.op_count, m_cnt & 32'hFFFF);
      chk("op_count_wrap4", bif4.op_count, m_cnt % 16);
      if (prev_stall) begin
        chk("stall_hold_o", bif.rsp_o, prev_o);
        chk("stall_hold_id", bif.rsp_id, prev_id);
      end
`ifdef MUL8U_SCHED_ERRCHK_EN
      chk("err_max", bif.err_max, m_errmax);
`endif
      if (!rst && bif.rsp_valid && bif.rsp_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rsp_unexpected actual=id %0d required=no response", bif.rsp_id);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_id", bif.rsp_id, e.id);
          chk("rsp_o", bif.rsp_o, e.o);
`ifdef MUL8U_SCHED_ERRCHK_EN
          chk("rsp_exact", bif.rsp_exact, e.ex);
          chk("rsp_err", bif.rsp_err, e.err);
          if (e.err > m_errmax) m_errmax = e.err;
`endif
          log_ids.push_back(int'(bif.rsp_id));
        end
      end
      prev_stall = !rst && bif.rsp_valid && !bif.rsp_ready;
      prev_o     = bif.rsp_o;
      prev_id    = bif.rsp_id;
    end
  end

  task automatic single_op(input int idx, input logic [7:0] a, input logic [7:0] b,
                           input logic [15:0] exp_o, input int exp_cnt);
    bif.req_a[idx*8 +: 8] = a;
    bif.req_b[idx*8 +: 8] = b;
    bif.req_valid[idx]    = 1'b1;
    bif.rsp_ready         = 1'b1;
    @(posedge clk); #1;
    bif.req_valid[idx] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("single_valid", bif.rsp_valid, 1);
    chk("single_id", bif.rsp_id, idx);
    chk("single_o", bif.rsp_o, exp_o);
    chk("single_count", bif.op_count, exp_cnt);
`ifdef MUL8U_SCHED_ERRCHK_EN
    chk("single_exact", bif.rsp_exact, int'(a) * int'(b));
`endif
    @(posedge clk); #1;
  endtask

  // Random lanes obeying the hold-until-ready contract; called just after a rising edge.
  task automatic run_cycles(input int n, input int pvld, input int prdy);
    logic [3:0] acc;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      acc = bif.req_ready;
      @(posedge clk); #1;
      for (int i = 0; i < NREQ; i++) begin
        if (acc[i]) bif.req_valid[i] = 1'b0;
        if (!bif.req_valid[i] && ($urandom_range(99) < pvld)) begin
          bif.req_valid[i]      = 1'b1;
          bif.req_a[i*8 +: 8]   = 8'($urandom);
          bif.req_b[i*8 +: 8]   = 8'($urandom);
        end
      end
      bif.rsp_ready = ($urandom_range(99) < prdy);
    end
  endtask

  task automatic finish_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  initial begin : watchdog
    #1000000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    finish_run();
  end

  initial begin : main
    logic [3:0] acc;
    int         budget;
    bif.req_valid = '0;
    bif.req_a     = '0;
    bif.req_b     = '0;
    bif.rsp_ready = 1'b1;
    rst           = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_req_ready", bif.req_ready, 0);
    chk("reset_rsp_valid", bif.rsp_valid, 0);
    chk("reset_rsp_id", bif.rsp_id, 0);
    chk("reset_rsp_o", bif.rsp_o, 0);
    chk("reset_op_count", bif.op_count, 0);
    chk("reset_busy", bif.busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    single_op(2, 8'hFF, 8'hFF, 16'hE080, 1);
`ifdef MUL8U_SCHED_ERRCHK_EN
    @(negedge clk);
    chk("single_err_max", bif.err_max, 16'h1D81);
    @(posedge clk); #1;
`endif
    single_op(0, 8'hC0, 8'hC0, 16'hC080, 2);
    single_op(3, 8'h1F, 8'h1F, 16'h0000, 3);

    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      bif.req_a[i*8 +: 8] = 8'($urandom);
      bif.req_b[i*8 +: 8] = 8'($urandom);
    end
    bif.req_valid = 4'hF;
    log_ids.delete();
    repeat (8) @(posedge clk);
    #1;
    bif.req_valid = '0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("rr_count", log_ids.size(), 8);
    for (int k = 0; k < 8 && k < log_ids.size(); k++) begin
      chk("rr_order", log_ids[k], k % 4);
    end
    chk("rr_op_count", bif.op_count, 8);
    @(posedge clk); #1;

    run_cycles(150, 60, 75);
    run_cycles(5, 100, 100);
    run_cycles(3, 100, 0);
    run_cycles(150, 50, 70);
    run_cycles(10, 100, 100);

    @(negedge clk);
    chk("prerst_busy", bif.busy, 1);
    chk("prerst_valid", bif.rsp_valid, 1);
    @(posedge clk); #1;
    rst           = 1'b1;
    bif.req_valid = '0;
    bif.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_rsp_valid", bif.rsp_valid, 0);
    chk("midrst_busy", bif.busy, 0);
    chk("midrst_op_count", bif.op_count, 0);
    @(posedge clk); #1;
    rst           = 1'b0;
    bif.req_valid = 4'b1010;
    @(negedge clk);
    acc = bif.req_ready;
    chk("first_grant_after_rst", acc, 4'b0010);
    @(posedge clk); #1;
    bif.req_valid = bif.req_valid & ~acc;

    run_cycles(200, 60, 80);
    run_cycles(20, 0, 100);

    budget = 0;
    while ((bif.busy !== 1'b0 || exp_q.size() != 0) && budget < 50) begin
      @(posedge clk); #1;
      budget++;
    end
    @(negedge clk);
    chk("drain_queue_empty", exp_q.size(), 0);
    chk("drain_idle", bif.busy, 0);
    finish_run();
  end

endmodule
